// File: rtl/tz_pkg.sv
// tz_pkg: shared states, default sizes and round-robin pick for the trailing-zero scheduler
package tz_pkg;
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  localparam int NREQ_D  = 4;
  localparam int WIDTH_D = 8;
  localparam int IDW_D   = 2;
  localparam int CW_D    = 4;
  // first set index scanning last+1, last+2, ... modulo n (n <= 8)
  function automatic logic [2:0] rr_next(input logic [7:0] valid, input logic [2:0] last, input int n);
    logic [2:0] g;
    logic found;
    int j;
    g = '0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      j = (int'(last) + i) % n;
      if (i <= n && !found && valid[j[2:0]]) begin
        g = j[2:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/tz_serial_engine.sv
// tz_serial_engine: one-bit-per-cycle trailing-zero counter
module tz_serial_engine import tz_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int CW    = CW_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] operand,
  input  logic             step,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic             zero
);
  logic [WIDTH-1:0] op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             adv;
  assign zero  = cnt_q == CW'(WIDTH);
  assign done  = op_q[0] | zero;
  assign count = cnt_q;
  assign adv   = step && !done;
  // load clears the count; each step shifts out one zero until a one or WIDTH zeros are seen
  always_comb begin
    op_d  = load ? operand : adv ? op_q >> 1 : op_q;
    cnt_d = load ? '0 : adv ? cnt_q + CW'(1) : cnt_q;
  end
  // engine registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tz_job_scheduler.sv
// tz_job_scheduler: round-robin sharing of one serial trailing-zero engine among NREQ requesters
module tz_job_scheduler import tz_pkg::*; #(
  parameter int NREQ  = NREQ_D,
  parameter int WIDTH = WIDTH_D,
  parameter int IDW   = IDW_D,
  parameter int CW    = CW_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [CW-1:0]         rsp_count,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic [15:0]           jobs_done
);
  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d, grant;
  logic [CW-1:0]  rsp_count_q, rsp_count_d, eng_count;
  logic           rsp_zero_q, rsp_zero_d, eng_done, eng_zero, accept;
  logic [15:0]    jobs_q, jobs_d;
  assign grant     = IDW'(rr_next(8'(req_valid), 3'(last_q), NREQ));
  assign accept    = state_q == IDLE && |req_valid && !rst;
  assign req_ready = accept ? NREQ'(1) << grant : '0;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_id    = rsp_id_q;
  assign rsp_count = rsp_count_q;
  assign rsp_zero  = rsp_zero_q;
  assign jobs_done = jobs_q;
  tz_serial_engine #(.WIDTH(WIDTH), .CW(CW)) u_eng (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .operand (req_data[int'(grant)*WIDTH +: WIDTH]),
    .step    (state_q == RUN),
    .done    (eng_done),
    .count   (eng_count),
    .zero    (eng_zero)
  );
  // next state: accept in IDLE, capture result when the engine finishes, retire on handshake
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_count_d = rsp_count_q;
    rsp_zero_d  = rsp_zero_q;
    jobs_d      = jobs_q;
    if (accept) begin
      state_d = RUN;
      id_d    = grant;
    end
    if (state_q == RUN && eng_done) begin
      state_d     = RESP;
      rsp_id_d    = id_q;
      rsp_count_d = eng_count;
      rsp_zero_d  = eng_zero;
    end
    if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      last_d  = id_q;
      jobs_d  = jobs_q + 16'd1;
    end
  end
  // scheduler FSM and response registers; pointer starts at NREQ-1 so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      rsp_zero_q  <= 1'b0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
      rsp_zero_q  <= rsp_zero_d;
      jobs_q      <= jobs_d;
    end
  end
endmodule

// File: doc/tz_job_scheduler.md
Name: tz_job_scheduler

Overview:
- Shares one serial trailing-zero counting engine between NREQ requesters.
- Arbitrates pending jobs round-robin, loads the winner's operand, sequences the engine to completion, then returns the count with the requester ID on a single valid/ready response channel.
- Sits between the requesting datapath blocks and the trailing-zero engine; processes one job at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits.
- IDW, 2, requester ID width; constraint NREQ <= 2**IDW.
- CW, 4, count width; constraint 2**CW > WIDTH, so a count of WIDTH (zero operand) is representable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester job pending.
- req_data  in  NREQ*WIDTH  operands; requester i is at [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot acceptance strobe.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  requester index of the result.
- rsp_count  out  CW  number of trailing zeros (0..WIDTH).
- rsp_zero  out  1  operand was all zeros (rsp_count == WIDTH).
- busy  out  1  high in any state other than IDLE.
- jobs_done  out  16  completed-job counter; wraps modulo 2**16.

Behaviour:
- Reset (asynchronous, any state, including mid-job):
  - State goes to IDLE.
  - rsp_valid, busy, req_ready and rsp_zero all 0; rsp_id 0, rsp_count 0, jobs_done 0.
  - Round-robin pointer last = NREQ-1, so requester 0 wins first.
  - Any in-flight job is dropped. Requesters must hold req_valid until they see req_ready, so no job is lost except the one already accepted.
- States: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid bit is set, the grant g is the first set index scanning last+1, last+2, ... modulo NREQ.
  - req_ready[g] is asserted combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: the engine operand is loaded with req_data[g], count is cleared to 0, id is set to g, state goes to RUN.
  - req_ready is 0 in every state except IDLE.
- RUN (engine step, once per edge):
  - If operand[0]==0 and count<WIDTH: shift the operand right by 1 and increment count.
  - Otherwise: go to RESP, registering rsp_count=count, rsp_zero=(count==WIDTH) and rsp_id=id.
- Latency:
  - For an operand with k trailing zeros (k=WIDTH when the operand is 0), rsp_valid rises k+1 cycles after the acceptance edge.
  - Minimum 1 cycle (operand bit0=1); maximum WIDTH+1 cycles.
- RESP:
  - rsp_valid=1; rsp_id, rsp_count and rsp_zero are held stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid goes to 0, last=id, jobs_done increments, state goes to IDLE.
  - rsp_ready=0 stalls indefinitely with no state change.
  - A new job is never accepted on the same edge as a response handshake. Minimum job period is k+3 cycles.
- The round-robin pointer updates only on a completed response, not on acceptance.
- req_valid deasserting for a requester that was not granted has no effect.
- req_data of the granted requester is sampled only on the acceptance edge; later changes do not affect the running job.
- jobs_done wraps from 16'hFFFF to 0.
- rsp_id, rsp_count and rsp_zero outside RESP hold their last values (0 after reset).

Decomposition:
- Shared package tz_pkg holds:
  - the state enum (IDLE, RUN, RESP);
  - default WIDTH, CW, IDW and NREQ constants;
  - a function computing the round-robin next index from the valid vector and the last grant.
- One sub-module, tz_serial_engine:
  - ports: load, operand, step enable;
  - outputs: done, count, zero flag;
  - implements the shift/count loop. The scheduler owns arbitration, the FSM, the response register and jobs_done.

Test Plan:
- Single job: req_valid=4'b0001, req_data[0]=8'b0010_1000 -> req_ready[0] pulses 1 cycle; rsp_valid rises 4 cycles later with rsp_id=0, rsp_count=3, rsp_zero=0; jobs_done=1 after the handshake.
- Zero and odd operands:
  - 8'h00 -> rsp_count=8, rsp_zero=1, 9-cycle latency.
  - 8'h01 -> rsp_count=0, 1-cycle latency.
- Round-robin: all four req_valid held high with data 8'h80, 8'h02, 8'h04, 8'h01 -> grants in order 0,1,2,3,0; rsp_count 7,1,2,0; no requester is granted twice before the others are served.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid held and outputs stable, no req_ready pulses, busy=1; raise rsp_ready -> one handshake, then IDLE for one cycle before the next grant.
- Reset mid-RUN: assert rst during the job for 8'h40 -> busy=0, rsp_valid=0 and jobs_done=0 immediately (asynchronously); after release, requester 0 (still valid) is granted first.
- Counter wrap: preload-equivalent run of 65536 jobs (or forced state) -> jobs_done wraps to 0 on the next completion.
